// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the program-driven fetch unit (package fetch_pkg).
// Instruction fields: mode[7], opcode[6:4], rd/rs1[3:2], rs2[1:0].
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    localparam logic [7:0] NOP_INSTR  = 8'h00;
    localparam logic [7:0] HALT_INSTR = 8'hFF;

    localparam int MODE_BIT  = 7;
    localparam int OPCODE_HI = 6;
    localparam int OPCODE_LO = 4;
    localparam int RD_HI     = 3;
    localparam int RD_LO     = 2;
    localparam int RS2_HI    = 1;
    localparam int RS2_LO    = 0;

    function automatic logic is_halt(input logic [7:0] instr);
        return instr == HALT_INSTR;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Program-load bus into the fetch unit: the loader is master, the fetch unit is slave.
interface pc_fetch_unit_if #(
    parameter int ADDR_W = 4,
    parameter int IW     = 8
) ();
    logic              load_en;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [IW-1:0]     load_data;

    modport master (
        output load_en,
        output load_we,
        output load_addr,
        output load_data
    );

    modport slave (
        input load_en,
        input load_we,
        input load_addr,
        input load_data
    );
endinterface

// File: rtl/pc_fetch_unit_instr_ram.sv
// Instruction memory: synchronous write, asynchronous read, zero at power-up.
module instr_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int IW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [IW-1:0]     wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [IW-1:0]     rdata
);

    // Reset deliberately does not clear the array; only the power-up image is zero.
    logic [IW-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch unit: loadable instruction RAM, PC and run/halt FSM driving the IF/ID register.
// Build option FETCH_PC_WRAP_EN: PC wraps at the end of memory instead of halting.
//
// state   | meaning
// IDLE    | waiting for load or run, NOPs out
// LOAD    | load bus may write the instruction RAM
// RUN     | one fetch per unstalled cycle
// HALT    | HALT word or end of memory reached, halted high
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int IW     = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 stall,
    input  logic                 run,
    pc_fetch_unit_if.slave       load_bus,
    output logic [IW-1:0]        if_id_reg,
    output logic                 if_id_valid,
    output logic [ADDR_W-1:0]    pc,
    output logic                 halted
);

    fetch_state_e      state, state_n;
    logic [ADDR_W-1:0] pc_n;
    logic [IW-1:0]     ir_n;
    logic              valid_n;
    logic              end_seen, end_seen_n;
    logic [IW-1:0]     instr;
    logic              ram_we;

    assign ram_we = (state == ST_LOAD) && load_bus.load_we;

    instr_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .IW    (IW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(load_bus.load_addr),
        .wdata(load_bus.load_data),
        .raddr(pc),
        .rdata(instr)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            pc          <= '0;
            if_id_reg   <= NOP_INSTR;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
            end_seen    <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            if_id_reg   <= ir_n;
            if_id_valid <= valid_n;
            halted      <= (state_n == ST_HALT);
            end_seen    <= end_seen_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ir_n       = NOP_INSTR;
        valid_n    = 1'b0;
        end_seen_n = 1'b0;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (load_bus.load_en) begin
                    state_n = ST_LOAD;
                end else if (run) begin
                    state_n = ST_RUN;
                    pc_n    = '0;
                end
            end
            ST_LOAD: begin
                if (!load_bus.load_en) begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (load_bus.load_en) begin
                    state_n = ST_LOAD;
                end else if (stall) begin
                    ir_n       = if_id_reg;
                    valid_n    = if_id_valid;
                    end_seen_n = end_seen;
                end else if (end_seen || is_halt(instr)) begin
                    // Last word already forwarded, or HALT word: never forward HALT itself.
                    state_n = ST_HALT;
                end else begin
                    ir_n    = instr;
                    valid_n = 1'b1;
`ifdef FETCH_PC_WRAP_EN
                    pc_n    = pc + ADDR_W'(1);
`else
                    if (pc == ADDR_W'(DEPTH - 1)) begin
                        end_seen_n = 1'b1;
                    end else begin
                        pc_n = pc + ADDR_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: per-cycle behavioural model plus directed literal checks.
module tb_pc_fetch_unit;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       stall = 1'b0;
    logic       run = 1'b0;
    logic [7:0] if_id_reg;
    logic       if_id_valid;
    logic [3:0] pc;
    logic       halted;

    pc_fetch_unit_if #(.ADDR_W(4), .IW(8)) bus ();

    pc_fetch_unit #(.DEPTH(DEPTH), .ADDR_W(4), .IW(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .stall      (stall),
        .run        (run),
        .load_bus   (bus.slave),
        .if_id_reg  (if_id_reg),
        .if_id_valid(if_id_valid),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model: modes named by what the unit is doing.
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3;
    int       m_mode = M_IDLE;
    int       m_pc = 0;
    int       m_ir = 0;
    bit       m_v = 0;
    bit       m_last_done = 0;
    bit [7:0] m_mem [DEPTH];

    initial for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;

    always @(posedge clk) begin
        if (!resetn) begin
            m_mode = M_IDLE; m_pc = 0; m_ir = 0; m_v = 0; m_last_done = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_HALT: begin
                    m_ir = 0; m_v = 0;
                    if (bus.load_en) m_mode = M_LOAD;
                    else if (run) begin m_mode = M_RUN; m_pc = 0; end
                end
                M_LOAD: begin
                    m_ir = 0; m_v = 0;
                    if (bus.load_we) m_mem[bus.load_addr] = bus.load_data;
                    if (!bus.load_en) m_mode = M_IDLE;
                end
                default: begin
                    if (bus.load_en) begin
                        m_mode = M_LOAD; m_ir = 0; m_v = 0;
                    end else if (!stall) begin
                        if (m_last_done || m_mem[m_pc] == 8'hFF) begin
                            m_mode = M_HALT; m_ir = 0; m_v = 0;
                        end else begin
                            m_ir = m_mem[m_pc]; m_v = 1;
`ifdef FETCH_PC_WRAP_EN
                            m_pc = (m_pc + 1) % DEPTH;
`else
                            if (m_pc == DEPTH - 1) m_last_done = 1;
                            else m_pc = m_pc + 1;
`endif
                        end
                    end
                end
            endcase
            if (m_mode != M_RUN) m_last_done = 0;
        end
        chk_en = 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ir", int'(if_id_reg), m_ir);
            check("model_valid", int'(if_id_valid), int'(m_v));
            check("model_pc", int'(pc), m_pc);
            check("model_halted", int'(halted), int'(m_mode == M_HALT));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [7:0] d);
        bus.load_we = 1'b1; bus.load_addr = a; bus.load_data = d;
        tick();
        bus.load_we = 1'b0;
    endtask

    task automatic start_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    initial begin
        bus.load_en = 1'b0; bus.load_we = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        tick(); tick();
        check("rst_pc", int'(pc), 0);
        check("rst_ir", int'(if_id_reg), 8'h00);
        check("rst_valid", int'(if_id_valid), 0);
        check("rst_halted", int'(halted), 0);
        resetn = 1'b1;

        // basic program 11, 34, HALT
        bus.load_en = 1'b1; tick();
        load_word(4'd0, 8'h11); load_word(4'd1, 8'h34); load_word(4'd2, 8'hFF);
        bus.load_en = 1'b0; tick();
        start_run();
        check("run_pc0", int'(pc), 0);
        check("run_valid0", int'(if_id_valid), 0);
        tick();
        check("f0_ir", int'(if_id_reg), 8'h11);
        check("f0_valid", int'(if_id_valid), 1);
        check("f0_pc", int'(pc), 1);
        tick();
        check("f1_ir", int'(if_id_reg), 8'h34);
        check("f1_pc", int'(pc), 2);
        tick();
        check("halt_ir", int'(if_id_reg), 8'h00);
        check("halt_valid", int'(if_id_valid), 0);
        check("halt_flag", int'(halted), 1);
        check("halt_pc", int'(pc), 2);

        // restart from HALT with a 3-cycle stall on the first word
        start_run();
        check("rerun_pc", int'(pc), 0);
        check("rerun_halted", int'(halted), 0);
        tick();
        check("rerun_ir", int'(if_id_reg), 8'h11);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ir", int'(if_id_reg), 8'h11);
            check("stall_pc", int'(pc), 1);
            check("stall_valid", int'(if_id_valid), 1);
        end
        stall = 1'b0;
        tick();
        check("post_stall_ir", int'(if_id_reg), 8'h34);
        tick();
        check("post_stall_halt", int'(halted), 1);

        // reset mid-program
        start_run(); tick();
        check("pre_rst_pc", int'(pc), 1);
        resetn = 1'b0; tick(); resetn = 1'b1;
        check("mid_rst_pc", int'(pc), 0);
        check("mid_rst_ir", int'(if_id_reg), 8'h00);
        check("mid_rst_valid", int'(if_id_valid), 0);
        start_run(); tick();
        check("mem_kept0", int'(if_id_reg), 8'h11);
        tick();
        check("mem_kept1", int'(if_id_reg), 8'h34);
        tick();
        check("mem_kept_halt", int'(halted), 1);
        resetn = 1'b0; tick(); resetn = 1'b1;

        // load_en beats run in IDLE; fill with no HALT
        bus.load_en = 1'b1; run = 1'b1; tick(); run = 1'b0;
        check("prio_valid", int'(if_id_valid), 0);
        check("prio_pc", int'(pc), 0);
        check("prio_halted", int'(halted), 0);
        for (int i = 0; i < DEPTH; i++) load_word(4'(i), 8'h11);
        bus.load_en = 1'b0; tick();
        start_run();
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            check("fill_ir", int'(if_id_reg), 8'h11);
            check("fill_valid", int'(if_id_valid), 1);
`ifdef FETCH_PC_WRAP_EN
            check("fill_pc", int'(pc), (k + 1) % DEPTH);
`else
            check("fill_pc", int'(pc), (k < DEPTH - 1) ? k + 1 : DEPTH - 1);
`endif
        end
        tick();
`ifdef FETCH_PC_WRAP_EN
        check("wrap_valid", int'(if_id_valid), 1);
        check("wrap_pc", int'(pc), 1);
`else
        check("end_halted", int'(halted), 1);
        check("end_valid", int'(if_id_valid), 0);
        check("end_pc", int'(pc), 15);
        start_run(); tick();
`endif

        // RUN -> LOAD flushes the IF/ID register
        check("pre_load_valid", int'(if_id_valid), 1);
        bus.load_en = 1'b1; tick();
        check("run_load_ir", int'(if_id_reg), 8'h00);
        check("run_load_valid", int'(if_id_valid), 0);
        bus.load_en = 1'b0; tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
